// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4-Lite response codes, protection default and the
// command-master state encoding.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } axi_mst_state_e;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: single-outstanding AXI4-Lite master. Turns a
// valid/ready command stream into AW/W/B or AR/R transactions and returns
// one response per command; keeps saturating write/read/error counters.
// Ports: aclk, areset (sync, active-high); cmd_* command stream in;
// rsp_* response stream out; m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite master;
// wr_count/rd_count/err_count statistics.
module axi4_lite_cmd_master
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,

    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,

    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,

    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,

    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,

    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    rd_count,
    output logic [CNT_WIDTH-1:0]    err_count
);

    axi_mst_state_e state;

    logic aw_done;
    logic w_done;
    logic aw_hs;
    logic w_hs;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;

    assign m_awprot = AXI_PROT_DEFAULT;
    assign m_arprot = AXI_PROT_DEFAULT;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            m_awaddr  <= '0;
            m_awvalid <= 1'b0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_araddr  <= '0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            m_awaddr  <= cmd_addr;
                            m_wdata   <= cmd_wdata;
                            m_wstrb   <= cmd_wstrb;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= ST_WR_REQ;
                        end else begin
                            m_araddr  <= cmd_addr;
                            m_arvalid <= 1'b1;
                            state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently, in either order
                    // or in the same cycle.
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        m_bready <= 1'b1;
                        state    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= m_bresp;
                        wr_count  <= sat_inc(wr_count);
                        if (m_bresp != RESP_OKAY)
                            err_count <= sat_inc(err_count);
                        state <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= m_rdata;
                        rsp_resp  <= m_rresp;
                        rd_count  <= sat_inc(rd_count);
                        if (m_rresp != RESP_OKAY)
                            err_count <= sat_inc(err_count);
                        state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
